nn_digit_driver: RTL and testbench

- Host-side initiator for the Neural_Network core.
- Collects an 8-bit grayscale 28x28 pixel stream, binarises it into the 784-bit layer_0 image and pulses start.
- Waits for finish, captures the ten 32-bit class scores and runs a sequential signed argmax.
- Presents the recognised digit on a valid/ready output to the Sudoku solver.

---
 rtl/nn_pkg.sv | 27 ++
 rtl/nn_argmax_seq.sv | 77 +++++++
 rtl/nn_digit_driver.sv | 152 +++++++++++++++
 tb/tb_nn_digit_driver.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants, FSM states and score-slice helper
// for the Neural_Network host-side digit driver.
package nn_pkg;

  localparam int IMG_PIXELS = 784;
  localparam int PIX_BITS   = 8;
  localparam int THRESH     = 128;
  localparam int CLASSES    = 10;
  localparam int SCORE_BITS = 32;
  localparam int CNT_W      = 10;
  localparam int IDX_W      = 4;
  localparam int WDOG_W     = 17;

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_ARGMAX,
    S_OUT
  } state_t;

  // Class 0 occupies the most significant slice of layer_2.
  function automatic int score_lsb(input int c);
    return (CLASSES - 1 - c) * SCORE_BITS;
  endfunction

endpackage

// File: rtl/nn_argmax_seq.sv
// Sequential signed argmax over the captured class scores,
// one class per cycle; ties keep the lower index.
module nn_argmax_seq
  import nn_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [SCORE_BITS*CLASSES-1:0] scores,
  output logic [IDX_W-1:0]             idx,
  output logic signed [SCORE_BITS-1:0] best,
  output logic                         done
);

  logic [SCORE_BITS*CLASSES-1:0] scores_q, scores_d;
  logic signed [SCORE_BITS-1:0]  best_q, best_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [IDX_W-1:0]              i_q, i_d;
  logic                          run_q, run_d;
  logic                          done_q, done_d;

  logic signed [SCORE_BITS-1:0]  sc [CLASSES];

  for (genvar c = 0; c < CLASSES; c++) begin : g_slice
    assign sc[c] = scores_q[score_lsb(c) +: SCORE_BITS];
  end

  always_comb begin
    scores_d = scores_q;
    best_d   = best_q;
    idx_d    = idx_q;
    i_d      = i_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (load) begin
      scores_d = scores;
      best_d   = $signed(scores[score_lsb(0) +: SCORE_BITS]);
      idx_d    = '0;
      i_d      = IDX_W'(1);
      run_d    = 1'b1;
    end else if (run_q) begin
      if (sc[i_q] > best_q) begin
        best_d = sc[i_q];
        idx_d  = i_q;
      end
      if (i_q == IDX_W'(CLASSES - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        i_d = i_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scores_q <= '0;
      best_q   <= '0;
      idx_q    <= '0;
      i_q      <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      scores_q <= scores_d;
      best_q   <= best_d;
      idx_q    <= idx_d;
      i_q      <= i_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign idx  = idx_q;
  assign best = best_q;
  assign done = done_q;

endmodule

// File: rtl/nn_digit_driver.sv
// Host-side initiator: binarises a 28x28 frame, starts the
// network, argmaxes its scores and hands the digit onward.
module nn_digit_driver
  import nn_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [PIX_BITS-1:0]           pix_data,
  input  logic                          pix_last,
  output logic                          nn_start,
  output logic [IMG_PIXELS-1:0]         nn_layer_0,
  input  logic [SCORE_BITS*CLASSES-1:0] nn_layer_2,
  input  logic                          nn_finish,
  output logic                          digit_valid,
  input  logic                          digit_ready,
  output logic [3:0]                    digit,
  output logic [SCORE_BITS-1:0]         digit_score,
  output logic                          err_timeout,
  output logic                          busy
);

  state_t                  state_q, state_d;
  logic [IMG_PIXELS-1:0]   layer_q, layer_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  logic                    start_q, start_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    dvalid_q, dvalid_d;
  logic [3:0]              digit_q, digit_d;
  logic [SCORE_BITS-1:0]   dscore_q, dscore_d;

  logic                    am_load;
  logic                    am_done;
  logic [IDX_W-1:0]        am_idx;
  logic signed [SCORE_BITS-1:0] am_best;

  logic                    pix_bin;
  logic [CNT_W-1:0]        wr_idx;

  assign pix_bin = pix_data >= PIX_BITS'(THRESH);
  assign wr_idx  = CNT_W'(IMG_PIXELS - 1) - cnt_q;
  // Scores are only valid in the finish cycle, so capture here.
  assign am_load = (state_q == S_WAIT) && nn_finish;

  nn_argmax_seq u_argmax (
    .clk    (clk),
    .rst    (rst),
    .load   (am_load),
    .scores (nn_layer_2),
    .idx    (am_idx),
    .best   (am_best),
    .done   (am_done)
  );

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    err_d    = 1'b0;
    digit_d  = digit_q;
    dscore_d = dscore_q;
    unique case (state_q)
      S_LOAD: begin
        if (pix_valid) begin
          layer_d[wr_idx] = pix_bin;
          if (cnt_q == CNT_W'(IMG_PIXELS - 1) || pix_last) begin
            state_d = S_START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (nn_finish) begin
          state_d = S_ARGMAX;
        end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_LOAD;
          layer_d = '0;
          cnt_d   = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_ARGMAX: begin
        if (am_done) begin
          state_d  = S_OUT;
          digit_d  = am_idx;
          dscore_d = am_best;
        end
      end
      S_OUT: begin
        if (digit_ready) begin
          state_d = S_LOAD;
          layer_d = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
    start_d  = (state_d == S_START);
    busy_d   = (state_d != S_LOAD);
    dvalid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOAD;
      layer_q  <= '0;
      cnt_q    <= '0;
      wdog_q   <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      dvalid_q <= 1'b0;
      digit_q  <= '0;
      dscore_q <= '0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      start_q  <= start_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      dvalid_q <= dvalid_d;
      digit_q  <= digit_d;
      dscore_q <= dscore_d;
    end
  end

  assign pix_ready   = (state_q == S_LOAD);
  assign nn_start    = start_q;
  assign nn_layer_0  = layer_q;
  assign digit_valid = dvalid_q;
  assign digit       = digit_q;
  assign digit_score = dscore_q;
  assign err_timeout = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_nn_digit_driver.sv
// Directed self-checking bench for nn_digit_driver
// (watchdog shortened to 50 cycles).
module tb_nn_digit_driver;

  logic         clk = 1'b0;
  logic         rst;
  logic         pix_valid;
  logic         pix_ready;
  logic [7:0]   pix_data;
  logic         pix_last;
  logic         nn_start;
  logic [783:0] nn_layer_0;
  logic [319:0] nn_layer_2;
  logic         nn_finish;
  logic         digit_valid;
  logic         digit_ready;
  logic [3:0]   digit;
  logic [31:0]  digit_score;
  logic         err_timeout;
  logic         busy;

  int pass_cnt = 0;
  int total    = 0;

  logic [31:0]  s [10];
  logic [783:0] exp_img;

  always #5 clk = ~clk;

  nn_digit_driver #(.TIMEOUT(50)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .nn_start    (nn_start),
    .nn_layer_0  (nn_layer_0),
    .nn_layer_2  (nn_layer_2),
    .nn_finish   (nn_finish),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .digit       (digit),
    .digit_score (digit_score),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  function automatic logic [319:0] pack_scores();
    logic [319:0] v;
    for (int c = 0; c < 10; c++)
      v[(9 - c) * 32 +: 32] = s[c];
    return v;
  endfunction

  task automatic push(input logic [7:0] d, input logic last);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = last;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  // Drives finish from S_WAIT and checks the 10-edge latency.
  task automatic run_finish(input logic [3:0] ed,
                            input logic [31:0] es,
                            input string nm);
    nn_layer_2 = pack_scores();
    nn_finish  = 1'b1;
    @(posedge clk);
    #1;
    nn_finish = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) nn_layer_2 = '0;
      if (k == 9) begin
        total++;
        if (digit_valid !== 1'b0)
          $display("FAIL %s_early: valid=%b want 0", nm, digit_valid);
        else pass_cnt++;
      end
    end
    total++;
    if (digit_valid !== 1'b1)
      $display("FAIL %s_lat: valid=%b want 1", nm, digit_valid);
    else pass_cnt++;
    total++;
    if (digit !== ed)
      $display("FAIL %s_digit: got %0d want %0d", nm, digit, ed);
    else pass_cnt++;
    total++;
    if (digit_score !== es)
      $display("FAIL %s_score: got %h want %h", nm, digit_score, es);
    else pass_cnt++;
  endtask

  task automatic handshake(input string nm);
    digit_ready = 1'b1;
    @(posedge clk);
    #1;
    digit_ready = 1'b0;
    total++;
    if (digit_valid !== 1'b0 || pix_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s_hs: valid=%b rdy=%b busy=%b want 0 1 0",
               nm, digit_valid, pix_ready, busy);
    else pass_cnt++;
    total++;
    if (nn_layer_0 !== '0)
      $display("FAIL %s_clr: img=%h want 0", nm, nn_layer_0);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_data = '0;
    pix_last = 1'b0;
    nn_layer_2 = '0;
    nn_finish = 1'b0;
    digit_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({nn_start, digit_valid, err_timeout, busy} !== 4'b0)
      $display("FAIL rst_ctl: st/v/err/busy=%b want 0000",
               {nn_start, digit_valid, err_timeout, busy});
    else pass_cnt++;
    total++;
    if (digit !== 4'd0 || digit_score !== 32'd0)
      $display("FAIL rst_dig: got %0d %h want 0 0", digit, digit_score);
    else pass_cnt++;
    total++;
    if (nn_layer_0 !== '0 || pix_ready !== 1'b1)
      $display("FAIL rst_img: rdy=%b want 1, img nonzero", pix_ready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    for (int p = 0; p < 783; p++) push(8'd255, 1'b0);
    total++;
    if (pix_ready !== 1'b1 || nn_start !== 1'b0)
      $display("FAIL ff_pre: rdy=%b start=%b want 1 0",
               pix_ready, nn_start);
    else pass_cnt++;
    push(8'd255, 1'b0);
    total++;
    if (pix_ready !== 1'b0 || nn_start !== 1'b1)
      $display("FAIL ff_start: rdy=%b start=%b want 0 1",
               pix_ready, nn_start);
    else pass_cnt++;
    total++;
    if (nn_layer_0 !== {784{1'b1}})
      $display("FAIL ff_img: got %h want all ones", nn_layer_0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total++;
    if (nn_start !== 1'b0 || busy !== 1'b1)
      $display("FAIL ff_pulse: start=%b busy=%b want 0 1",
               nn_start, busy);
    else pass_cnt++;
  endtask

  task automatic test_argmax_stall();
    for (int c = 0; c < 10; c++) s[c] = 32'h0000_0100;
    s[0] = 32'hFFFF_FF00;
    s[6] = 32'h8000_0000;
    s[3] = 32'h0000_0500;
    run_finish(4'd3, 32'h0000_0500, "am");
    for (int k = 0; k < 20; k++) begin
      nn_layer_2 = {10{32'h7FFF_FFFF}};
      @(posedge clk);
      #1;
      total++;
      if (digit_valid !== 1'b1 || digit !== 4'd3 ||
          digit_score !== 32'h500 || nn_layer_0 !== {784{1'b1}})
        $display("FAIL stall_%0d: v=%b d=%0d s=%h want 1 3 500",
                 k, digit_valid, digit, digit_score);
      else pass_cnt++;
    end
    nn_layer_2 = '0;
    handshake("stall");
  endtask

  task automatic test_threshold_tie();
    push(8'd128, 1'b0);
    push(8'd127, 1'b0);
    for (int p = 0; p < 782; p++) push(8'd0, 1'b0);
    exp_img = '0;
    exp_img[783] = 1'b1;
    total++;
    if (nn_layer_0 !== exp_img || nn_start !== 1'b1)
      $display("FAIL thr_img: got %h start=%b want %h 1",
               nn_layer_0, nn_start, exp_img);
    else pass_cnt++;
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) s[c] = 32'h0;
    s[2] = 32'h7FFF_FFFF;
    s[7] = 32'h7FFF_FFFF;
    run_finish(4'd2, 32'h7FFF_FFFF, "tie");
    handshake("tie");
  endtask

  task automatic test_early_last();
    for (int p = 0; p < 100; p++) push(8'd255, p == 99);
    exp_img = {{100{1'b1}}, {684{1'b0}}};
    total++;
    if (nn_layer_0 !== exp_img || nn_start !== 1'b1)
      $display("FAIL early_img: got %h start=%b want %h 1",
               nn_layer_0, nn_start, exp_img);
    else pass_cnt++;
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) s[c] = 32'hFFFF_FFFB;
    s[9] = 32'hFFFF_FFFF;
    run_finish(4'd9, 32'hFFFF_FFFF, "neg");
    handshake("neg");
  endtask

  task automatic test_ignored();
    nn_finish   = 1'b1;
    digit_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nn_finish   = 1'b0;
    digit_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || digit_valid !== 1'b0 ||
        pix_ready !== 1'b1 || err_timeout !== 1'b0)
      $display("FAIL ign: busy=%b v=%b rdy=%b err=%b want 0 0 1 0",
               busy, digit_valid, pix_ready, err_timeout);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int first;
    first = 0;
    push(8'd200, 1'b1);
    total++;
    if (nn_start !== 1'b1)
      $display("FAIL to_start: start=%b want 1", nn_start);
    else pass_cnt++;
    for (int n = 1; n <= 60 && first == 0; n++) begin
      @(posedge clk);
      #1;
      if (err_timeout === 1'b1) first = n;
    end
    total++;
    if (first != 51)
      $display("FAIL to_edge: err at edge %0d want 51", first);
    else pass_cnt++;
    total++;
    if (pix_ready !== 1'b1 || busy !== 1'b0 || nn_layer_0 !== '0)
      $display("FAIL to_load: rdy=%b busy=%b want 1 0, img clear",
               pix_ready, busy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total++;
    if (err_timeout !== 1'b0)
      $display("FAIL to_pulse: err=%b want 0", err_timeout);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    push(8'd255, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || nn_layer_0[783] !== 1'b1)
      $display("FAIL mid_pre: busy=%b bit783=%b want 1 1",
               busy, nn_layer_0[783]);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (nn_layer_0 !== '0 || busy !== 1'b0 || nn_start !== 1'b0 ||
        digit_valid !== 1'b0 || digit !== 4'd0 ||
        digit_score !== 32'd0 || err_timeout !== 1'b0)
      $display("FAIL mid_rst: busy=%b v=%b d=%0d s=%h want all 0",
               busy, digit_valid, digit, digit_score);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_argmax_stall();
    test_threshold_tie();
    test_early_last();
    test_ignored();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
